pmci_vdm_tlp_err_mon: RTL

- Parametrised per-channel monitor for multi-packet PCIe VDM (MCTP) messages entering the PMCI mailbox path.
- Tracks SOM/EOM framing, the 2-bit packet sequence number and the packet count on each of NUM_CH independent VDM streams.
- Latches sticky error flags, keeps saturating error and message counters, and raises a level interrupt.
- Host software reads and clears all state through a small CSR window located behind the PMCI DFH, alongside the VDM TLP status registers.

---
 rtl/pmci_vdm_tlp_err_mon_if.sv | 28 ++
 rtl/pmci_vdm_tlp_err_mon.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pmci_vdm_tlp_err_mon_if.sv
// VDM packet strobes and CSR window bundle for pmci_vdm_tlp_err_mon.
// The master drives packets and CSR requests; the monitor (slave) returns read data and irq.
interface pmci_vdm_tlp_err_mon_if #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 12
);
   logic [NUM_CH-1:0]   pkt_vld;
   logic [NUM_CH-1:0]   pkt_som;
   logic [NUM_CH-1:0]   pkt_eom;
   logic [2*NUM_CH-1:0] pkt_seq;
   logic                csr_wr;
   logic                csr_rd;
   logic [ADDR_W-1:0]   csr_addr;
   logic [63:0]         csr_wdata;
   logic [63:0]         csr_rdata;
   logic                csr_rvld;
   logic                irq;

   modport master (
      output pkt_vld, pkt_som, pkt_eom, pkt_seq, csr_wr, csr_rd, csr_addr, csr_wdata,
      input  csr_rdata, csr_rvld, irq
   );

   modport slave (
      input  pkt_vld, pkt_som, pkt_eom, pkt_seq, csr_wr, csr_rd, csr_addr, csr_wdata,
      output csr_rdata, csr_rvld, irq
   );
endinterface

// File: rtl/pmci_vdm_tlp_err_mon.sv
// Per-channel MCTP VDM framing monitor: SOM/EOM, sequence and length checks with sticky
// error flags, saturating counters, a small CSR window and a level interrupt.
module pmci_vdm_tlp_err_mon #(
   parameter int NUM_CH   = 2,
   parameter int CNT_W    = 16,
   parameter int MAX_PKTS = 64,
   parameter int ADDR_W   = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pmci_vdm_tlp_err_mon_if.slave io_bus
);
   localparam int PCNT_W = $clog2(MAX_PKTS + 1);
   localparam int E_ORPH = 0;
   localparam int E_SOM  = 1;
   localparam int E_SEQ  = 2;
   localparam int E_LEN  = 3;

   typedef enum logic {S_IDLE, S_IN_MSG} state_e;

   state_e              r_state   [NUM_CH];
   logic [1:0]          r_exp_seq [NUM_CH];
   logic [PCNT_W-1:0]   r_pkt_cnt [NUM_CH];
   logic [3:0]          r_sticky  [NUM_CH];
   logic [CNT_W-1:0]    r_err_cnt [NUM_CH];
   logic [CNT_W-1:0]    r_msg_cnt [NUM_CH];
   logic [NUM_CH-1:0]   r_en;
   logic [63:0]         r_rdata;
   logic                r_rvld;
   logic                r_irq;

   state_e              w_state_nxt [NUM_CH];
   logic [1:0]          w_exp_nxt   [NUM_CH];
   logic [PCNT_W-1:0]   w_pcnt_nxt  [NUM_CH];
   logic [3:0]          w_err_set   [NUM_CH];
   logic [3:0]          w_w1c       [NUM_CH];
   logic [NUM_CH-1:0]   w_msg_inc;
   logic [NUM_CH-1:0]   w_irq_vec;
   logic [63:0]         w_rdata;
   logic                w_ctrl_wr;
   logic                w_clr;
   logic                w_unused_wdata;

   assign w_unused_wdata = &{1'b0, io_bus.csr_wdata[63:NUM_CH+8], io_bus.csr_wdata[7:5]};

   // Framing FSM next state; a disabled channel sees no packets and falls back to IDLE.
   always_comb begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
         // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
         w_state_nxt[ch] = r_state[ch];
         w_exp_nxt[ch]   = r_exp_seq[ch];
         w_pcnt_nxt[ch]  = r_pkt_cnt[ch];
         w_err_set[ch]   = '0;
         w_msg_inc[ch]   = 1'b0;
         if (!r_en[ch]) begin
            w_state_nxt[ch] = S_IDLE;
         end else if (io_bus.pkt_vld[ch]) begin
            if (io_bus.pkt_som[ch]) begin
               w_err_set[ch][E_SOM] = (r_state[ch] == S_IN_MSG);
               if (io_bus.pkt_eom[ch]) begin
                  w_state_nxt[ch] = S_IDLE;
                  w_msg_inc[ch]   = 1'b1;
               end else begin
                  w_state_nxt[ch] = S_IN_MSG;
                  w_exp_nxt[ch]   = io_bus.pkt_seq[2*ch +: 2] + 2'd1;
                  w_pcnt_nxt[ch]  = PCNT_W'(1);
               end
            end else if (r_state[ch] == S_IDLE) begin
               w_err_set[ch][E_ORPH] = 1'b1;
            end else if (io_bus.pkt_seq[2*ch +: 2] != r_exp_seq[ch]) begin
               w_err_set[ch][E_SEQ] = 1'b1;
               w_state_nxt[ch]      = S_IDLE;
            end else if (r_pkt_cnt[ch] == PCNT_W'(MAX_PKTS)) begin
               w_err_set[ch][E_LEN] = 1'b1;
               w_state_nxt[ch]      = S_IDLE;
            end else begin
               w_pcnt_nxt[ch] = r_pkt_cnt[ch] + PCNT_W'(1);
               w_exp_nxt[ch]  = r_exp_seq[ch] + 2'd1;
               if (io_bus.pkt_eom[ch]) begin
                  w_state_nxt[ch] = S_IDLE;
                  w_msg_inc[ch]   = 1'b1;
               end
            end
         end
         // Message context only has meaning inside a message.
         if (w_state_nxt[ch] == S_IDLE) begin
            w_exp_nxt[ch]  = '0;
            w_pcnt_nxt[ch] = '0;
         end
      end
   end

   always_comb begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
         w_irq_vec[ch] = |r_sticky[ch];
      end
   end

   // CSR decode; read data always reflects the pre-write state.
   always_comb begin
      w_rdata   = '0;
      w_ctrl_wr = 1'b0;
      w_clr     = 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         w_w1c[ch] = '0;
         if (io_bus.csr_addr == ADDR_W'(8 * ch)) begin
            w_rdata[0]            = (r_state[ch] == S_IN_MSG);
            w_rdata[4:1]          = r_sticky[ch];
            w_rdata[7:6]          = r_exp_seq[ch];
            w_rdata[CNT_W+15:16]  = r_err_cnt[ch];
            w_w1c[ch]             = io_bus.csr_wr ? io_bus.csr_wdata[4:1] : 4'd0;
         end
         if (io_bus.csr_addr == ADDR_W'(128 + 8 * ch)) begin
            w_rdata[CNT_W-1:0] = r_msg_cnt[ch];
         end
      end
      if (io_bus.csr_addr == ADDR_W'('h100)) begin
         w_rdata[NUM_CH+7:8] = r_en;
         w_ctrl_wr           = io_bus.csr_wr;
         w_clr               = io_bus.csr_wr & io_bus.csr_wdata[0];
      end
      if (io_bus.csr_addr == ADDR_W'('h108)) begin
         w_rdata[NUM_CH-1:0] = w_irq_vec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: per-channel arrays are plain flops, not RAM, so each entry is reset explicitly.
         for (int ch = 0; ch < NUM_CH; ch++) begin
            r_state[ch]   <= S_IDLE;
            r_exp_seq[ch] <= '0;
            r_pkt_cnt[ch] <= '0;
            r_sticky[ch]  <= '0;
            r_err_cnt[ch] <= '0;
            r_msg_cnt[ch] <= '0;
         end
         r_en    <= '1;
         r_rdata <= '0;
         r_rvld  <= 1'b0;
         r_irq   <= 1'b0;
      end else begin
         // NOTE: non-blocking everywhere so every register samples pre-edge values.
         for (int ch = 0; ch < NUM_CH; ch++) begin
            r_state[ch]   <= w_state_nxt[ch];
            r_exp_seq[ch] <= w_exp_nxt[ch];
            r_pkt_cnt[ch] <= w_pcnt_nxt[ch];
            if (w_clr) begin
               r_sticky[ch]  <= '0;
               r_err_cnt[ch] <= '0;
               r_msg_cnt[ch] <= '0;
            end else begin
               r_sticky[ch] <= (r_sticky[ch] & ~w_w1c[ch]) | w_err_set[ch];
               if (|w_err_set[ch] && r_err_cnt[ch] != '1) begin
                  r_err_cnt[ch] <= r_err_cnt[ch] + CNT_W'(1);
               end
               if (w_msg_inc[ch] && r_msg_cnt[ch] != '1) begin
                  r_msg_cnt[ch] <= r_msg_cnt[ch] + CNT_W'(1);
               end
            end
         end
         if (w_ctrl_wr) begin
            r_en <= io_bus.csr_wdata[NUM_CH+7:8];
         end
         r_rvld  <= io_bus.csr_rd;
         r_rdata <= io_bus.csr_rd ? w_rdata : 64'd0;
         r_irq   <= |(w_irq_vec & r_en);
      end
   end

   assign io_bus.csr_rdata = r_rdata;
   assign io_bus.csr_rvld  = r_rvld;
   assign io_bus.irq       = r_irq;
endmodule
